// File: rtl/blockmem_rr_arb.sv
// blockmem_rr_arb: two-requester round-robin arbiter in front of one port of a
// block memory with a 1-cycle registered read. A requester may hold its lock
// input to keep ownership across consecutive transfers.
// Optional grant counters are enabled by defining BLOCKMEM_RR_ARB_STATS_EN.
module blockmem_rr_arb #(
   parameter int  G_MEMWIDTH = 32,
   parameter int  G_MEMDEPTH = 1024,
   localparam int AW         = $clog2(G_MEMDEPTH),
   localparam int WW         = ((G_MEMWIDTH - 1) / 8) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   // requester 0
   input  logic                  req0,
   input  logic                  lock0,
   input  logic [WW-1:0]         we0,
   input  logic [AW-1:0]         addr0,
   input  logic [G_MEMWIDTH-1:0] wdata0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [G_MEMWIDTH-1:0] rdata0,
   // requester 1
   input  logic                  req1,
   input  logic                  lock1,
   input  logic [WW-1:0]         we1,
   input  logic [AW-1:0]         addr1,
   input  logic [G_MEMWIDTH-1:0] wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [G_MEMWIDTH-1:0] rdata1,
`ifdef BLOCKMEM_RR_ARB_STATS_EN
   output logic [15:0]           gcnt0,
   output logic [15:0]           gcnt1,
`endif
   // memory port
   output logic                  mem_en,
   output logic [WW-1:0]         mem_we,
   output logic [AW-1:0]         mem_addr,
   output logic [G_MEMWIDTH-1:0] mem_din,
   input  logic [G_MEMWIDTH-1:0] mem_dout
);

   typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;

   state_t state_q, state_d;
   logic   lp_q, lp_d;          // last-grant pointer: 1 means requester 0 wins next contention
   logic   rvalid0_q, rvalid1_q;

   // Grant selection and next-state; grants are suppressed while reset is held.
   always_comb begin
      state_d = state_q;
      lp_d    = lp_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      if (!rst) begin
         case (state_q)
            ARB: begin
               if (req0 && (!req1 || lp_q)) begin
                  gnt0 = 1'b1;
               end else if (req1) begin
                  gnt1 = 1'b1;
               end
               if (gnt0 && lock0) begin
                  state_d = OWN0;
               end else if (gnt1 && lock1) begin
                  state_d = OWN1;
               end
            end
            OWN0: begin
               gnt0 = req0;
               // dropping the lock ends ownership even if this cycle's grant completes
               if (!lock0) state_d = ARB;
            end
            OWN1: begin
               gnt1 = req1;
               if (!lock1) state_d = ARB;
            end
            default: state_d = ARB;
         endcase
         if (gnt0) begin
            lp_d = 1'b0;
         end else if (gnt1) begin
            lp_d = 1'b1;
         end
      end
   end

   // Steer the granted requester's command onto the memory port.
   always_comb begin
      mem_en   = gnt0 | gnt1;
      mem_we   = '0;
      mem_addr = addr0;
      mem_din  = wdata0;
      if (gnt0) begin
         mem_we = we0;
      end else if (gnt1) begin
         mem_we   = we1;
         mem_addr = addr1;
         mem_din  = wdata1;
      end
   end

   // State, pointer and read-valid pipeline registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB;
         lp_q      <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lp_q      <= lp_d;
         rvalid0_q <= gnt0 && (we0 == '0);
         rvalid1_q <= gnt1 && (we1 == '0);
      end
   end

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   // Both requesters see the shared memory output; it is qualified by rvalid.
   assign rdata0  = mem_dout;
   assign rdata1  = mem_dout;

`ifdef BLOCKMEM_RR_ARB_STATS_EN
   logic [15:0] gcnt0_q, gcnt1_q;

   // Saturating per-requester grant counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gcnt0_q <= '0;
         gcnt1_q <= '0;
      end else begin
         if (gnt0 && (gcnt0_q != 16'hFFFF)) gcnt0_q <= gcnt0_q + 16'd1;
         if (gnt1 && (gcnt1_q != 16'hFFFF)) gcnt1_q <= gcnt1_q + 16'd1;
      end
   end

   assign gcnt0 = gcnt0_q;
   assign gcnt1 = gcnt1_q;
`endif

endmodule

// File: doc/blockmem_rr_arb.md
BLOCKMEM_RR_ARB -- requirements
Module: blockmem_rr_arb

Interface
REQ-001 SHALL have parameter G_MEMWIDTH, default 32, memory data width in bits.
REQ-002 SHALL have parameter G_MEMDEPTH, default 1024, memory depth in words; local AW = $clog2(G_MEMDEPTH), WW = ((G_MEMWIDTH-1)/8)+1.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have, per requester N in {0,1}: reqN input 1 (request); lockN input 1 (hold ownership); weN input WW (byte write enables, 0 = read); addrN input AW; wdataN input G_MEMWIDTH.
REQ-006 SHALL have, per requester N: gntN output 1 (transfer accepted this cycle); rvalidN output 1 (read data valid); rdataN output G_MEMWIDTH.
REQ-007 SHALL have memory-port outputs mem_en 1, mem_we WW, mem_addr AW and mem_din G_MEMWIDTH, plus input mem_dout G_MEMWIDTH, to drive one port of a dual-port block memory with 1-cycle registered read.

Function
REQ-008 SHALL accept at most one transfer per cycle; a transfer occurs when reqN=1 and gntN=1 in the same cycle.
REQ-009 gntN SHALL be combinational from the current state and reqN; gnt0 and gnt1 SHALL never both be 1.
REQ-010 Requester SHALL hold reqN, weN, addrN and wdataN stable until granted; the arbiter SHALL NOT require this for correctness.
REQ-011 FSM states SHALL be ARB, OWN0 and OWN1.
REQ-012 In ARB with a single requester, that requester SHALL be granted; with both, the one not equal to last-grant pointer lp SHALL be granted (round-robin).
REQ-013 lp SHALL update to N on every grant to N.
REQ-014 A grant to N with lockN=1 SHALL move the FSM to OWNN; in OWNN only requester N SHALL be granted, and the other SHALL see gnt=0.
REQ-015 In OWNN, a cycle with lockN=0, whether or not N is granted, SHALL return the FSM to ARB at the next edge; a grant in that cycle SHALL still complete.
REQ-016 On a grant, mem_en=1, mem_we=weN, mem_addr=addrN and mem_din=wdataN SHALL be driven in the same cycle; with no grant, mem_en=0 and mem_we=0.
REQ-017 A granted read (weN=0) SHALL assert rvalidN for exactly one cycle, the cycle after the grant; rdataN SHALL equal mem_dout (latency 1).
REQ-018 rdata0 and rdata1 SHALL both carry mem_dout and are meaningful only while their rvalid is 1.
REQ-019 A granted write (weN!=0) SHALL produce no rvalid; partial byte enables SHALL pass through unchanged.
REQ-020 Back-to-back reads from alternating requesters SHALL sustain one read per cycle, with rvalid following the grant order.
REQ-021 A write then a read to the same address on consecutive cycles SHALL return the written data, relying on memory read-after-write.

Reset
REQ-022 rst=1 SHALL asynchronously force state=ARB, lp=1 (requester 0 wins first contention), rvalid0=rvalid1=0 and the counters to 0.
REQ-023 While rst=1, gnt0=gnt1=0 and mem_en=0.
REQ-024 A read granted in the cycle before rst asserts SHALL NOT produce rvalid after reset release.

Configuration
REQ-025 Macro BLOCKMEM_RR_ARB_STATS_EN SHALL, when defined, add outputs gcnt0 and gcnt1 (16 bits each).
REQ-026 Each gcntN SHALL count grants to N and saturate at 16'hFFFF.
REQ-027 Without BLOCKMEM_RR_ARB_STATS_EN the gcntN ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset release, req0=req1=1 with reads at 0x010 and 0x020 -> gnt0 in cycle 0, gnt1 in cycle 1; rvalid0 in cycle 1 with mem[0x010], rvalid1 in cycle 2 with mem[0x020].
REQ-029 req0 write we=4'hF, addr 0x005, data 0xDEADBEEF, then req0 read 0x005 -> rvalid0 one cycle after the read grant, rdata0=0xDEADBEEF.
REQ-030 Partial write we=4'b0010, data 0x0000AB00 to a word holding 0x11223344, then read -> 0x1122AB44.
REQ-031 lock1=1 for 4 grants while req0 is held high -> gnt0=0 throughout; after lock1 drops, gnt0 is 1 in the next ARB cycle.
REQ-032 rst asserted the cycle after a read grant -> rvalid stays 0; the first post-reset contention is won by requester 0.
REQ-033 With BLOCKMEM_RR_ARB_STATS_EN defined, 70000 grants to requester 0 -> gcnt0=16'hFFFF and gcnt1=0.
